// File: rtl/mnist_pkg.sv
// ============================================================================
// Module      : mnist_pkg
// Description : Shared constants and types for the MNIST inference tail.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mnist_pkg;

    localparam int NUM_CLASSES = 10;
    localparam int SCORE_W     = 32;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } argmax_state_e;

    typedef logic signed [SCORE_W-1:0] score_t;

endpackage

`default_nettype wire

// File: rtl/max_update.sv
// ============================================================================
// Module      : max_update
// Description : Strict signed compare-and-select of (value, index) pairs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module max_update
    import mnist_pkg::*;
#(
    parameter int DATA_WIDTH = SCORE_W,
    parameter int IDX_W      = $clog2(NUM_CLASSES)
) (
    input  logic [DATA_WIDTH-1:0] cur_val,
    input  logic [IDX_W-1:0]      cur_idx,
    input  logic [DATA_WIDTH-1:0] new_val,
    input  logic [IDX_W-1:0]      new_idx,
    output logic [DATA_WIDTH-1:0] sel_val,
    output logic [IDX_W-1:0]      sel_idx
);

    logic w_take;

    // Strict greater-than keeps the earlier (lower) index on ties.
    assign w_take  = $signed(new_val) > $signed(cur_val);
    assign sel_val = w_take ? new_val : cur_val;
    assign sel_idx = w_take ? new_idx : cur_idx;

endmodule

`default_nettype wire

// File: rtl/argmax_seq.sv
// ============================================================================
// Module      : argmax_seq
// Description : Serial running signed argmax over one frame of class scores.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module argmax_seq
    import mnist_pkg::*;
#(
    parameter int DATA_WIDTH = SCORE_W,
    parameter int NUM_ARGS   = NUM_CLASSES,
    parameter int IDX_W      = $clog2(NUM_ARGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [IDX_W-1:0]      out_class,
    output logic [DATA_WIDTH-1:0] out_max,
    output logic                  out_err
);

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_ARGS - 1);

    argmax_state_e          r_state;
    logic [IDX_W-1:0]       r_cnt;
    logic [IDX_W-1:0]       r_idx;
    logic [DATA_WIDTH-1:0]  r_max;
    logic                   r_err;

    logic                   w_accept;
    logic                   w_at_limit;
    logic                   w_close;
    logic [DATA_WIDTH-1:0]  w_sel_val;
    logic [IDX_W-1:0]       w_sel_idx;

    max_update #(
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W)
    ) u_max_update (
        .cur_val (r_max),
        .cur_idx (r_idx),
        .new_val (in_data),
        .new_idx (r_cnt),
        .sel_val (w_sel_val),
        .sel_idx (w_sel_idx)
    );

    assign w_accept   = in_valid && (r_state == ACCUM);
    assign w_at_limit = (r_cnt == c_last_idx);
    assign w_close    = in_last || w_at_limit;

    // Handshake flags decode from state only, keeping out_ready off in_ready.
    assign in_ready  = (r_state == ACCUM);
    assign out_valid = (r_state == HOLD);
    assign out_class = r_idx;
    assign out_max   = r_max;
    assign out_err   = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ACCUM;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_max   <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (w_accept) begin
                        r_max <= w_sel_val;
                        r_idx <= w_sel_idx;
                        if (w_close) begin
                            // Error when in_last and the beat-count limit disagree.
                            r_err   <= in_last ^ w_at_limit;
                            r_state <= HOLD;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_max   <= '0;
                        r_err   <= 1'b0;
                        r_state <= ACCUM;
                    end
                end
                default: r_state <= ACCUM;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/argmax_seq.md
# argmax_seq

Sequential classification stage at the tail of the MNIST inference pipeline. Accepts the output-layer scores for one image as a serial valid/ready stream, one score per cycle. Tracks the running signed maximum and its index, then presents the winning class on a valid/ready result port. This replaces a wide parallel compare with one comparator reused across all beats, and provides frame checking and backpressure.

## Interface
- `DATA_WIDTH`, 32: width of one score (two's complement).
- `NUM_ARGS`, 10: scores per frame (classes); must be ≥ 2.
- `IDX_W`, `$clog2(NUM_ARGS)`: class index width (4 for 10 classes).
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `in_valid` in 1: score beat valid.
- `in_ready` out 1: block accepts a beat.
- `in_data` in `DATA_WIDTH`: score, signed.
- `in_last` in 1: marks final beat of frame.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts result.
- `out_class` out `IDX_W`: index of maximum score.
- `out_max` out `DATA_WIDTH`: maximum score value.
- `out_err` out 1: frame length mismatch (see Operation).

## Operation
- A beat is accepted when `in_valid && in_ready`. A result is taken when `out_valid && out_ready`.
- Registers:
  - `cnt` (`IDX_W` bits): beat index within the frame.
  - `max_r`: running maximum.
  - `idx_r`: index of the running maximum.
  - `err_r`: frame error flag.
- State machine has two states: `ACCUM` and `HOLD`.
- **ACCUM** (`in_ready`=1, `out_valid`=0):
  - On each accepted beat, if `$signed(in_data) > $signed(max_r)` then `max_r`←`in_data` and `idx_r`←`cnt`.
  - The comparison is strict, so on ties the lowest index wins.
  - `max_r` starts at 0. A frame of all non-positive scores therefore yields class 0 with `out_max`=0.
- **Frame end** is the accepted beat where `in_last`=1 OR `cnt`==`NUM_ARGS`-1, whichever comes first.
  - On frame end: update max/idx with that beat, go to `HOLD`, latch `err_r`.
  - `err_r` = `in_last` XOR (`cnt`==`NUM_ARGS`-1).
  - If a frame is short, the result covers only the beats received.
  - If `in_last` is missing at beat `NUM_ARGS`-1, the frame still closes at that beat.
- Otherwise an accepted beat increments `cnt`.
- **HOLD** (`in_ready`=0, `out_valid`=1):
  - `out_class`=`idx_r`, `out_max`=`max_r`, `out_err`=`err_r`. All stay stable until taken.
  - On take: `cnt`←0, `max_r`←0, `idx_r`←0, `err_r`←0, go to `ACCUM`.
- `in_valid` while `in_ready`=0 is ignored; the upstream must hold the beat.

## Timing
- Reset values (async assert, sync-safe deassert): state=`ACCUM`, `in_ready`=1, `out_valid`=0, `out_class`=0, `out_max`=0, `out_err`=0, `cnt`=0.
- Latency: `out_valid` rises on the cycle after the final beat is accepted.
- All outputs are registered or decoded directly from state; there is no combinational path from `in_*` to `out_*`.
- `in_ready` depends only on state; there is no combinational path from `out_ready` to `in_ready`.
  - The cycle in which the result is taken still has `in_ready`=0.
  - The first beat of the next frame can be accepted on the following cycle.
- Minimum frame period is `NUM_ARGS`+1 cycles with `out_ready` held high.
- Gaps in `in_valid` stall the frame with no state change.
- Reset mid-frame or in `HOLD`: partial frame or pending result is discarded, and all outputs return to reset values immediately.

## Structure
- Shared package `mnist_pkg` holds:
  - the `NUM_CLASSES`=10 and `SCORE_W`=32 constants used as parameter defaults;
  - typedef `argmax_state_e` {`ACCUM`, `HOLD`};
  - typedef `score_t` (`logic signed [SCORE_W-1:0]`).
- One sub-module, `max_update`, is natural. It is combinational and implements the strict signed compare and select of (value, index) pairs. The top instantiates it once.
- The FSM and counters stay in the top module.

## Test plan
- Scores 3,-1,7,7,2,0,5,6,1,4 with `in_last` on beat 9, `out_ready`=1 → `out_class`=2, `out_max`=7, `out_err`=0, `out_valid` one cycle after beat 9.
- All ten scores = -5 → `out_class`=0, `out_max`=0, `out_err`=0.
- Scores 0x7FFFFFFF at index 8, 0x80000000 elsewhere → `out_class`=8, confirming signed compare.
- `in_last` on beat 4 with max 9 at index 3 → `out_class`=3, `out_max`=9, `out_err`=1; the next frame starts with `cnt`=0.
- `out_ready`=0 for 5 cycles after result → `out_valid` and data held stable, `in_ready`=0. After the take, the next frame's beat 0 is accepted on the following cycle and the result matches an independent frame.
- `rst_n` pulsed low at beat 6 of a frame → `out_valid`=0 and `in_ready`=1 immediately. A following full frame of 1..10 yields `out_class`=9, `out_max`=10.
